// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display arbiter: requester count,
// FSM state encoding and the dwell-time conversion helper.
package display_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_e;

  function automatic int ms_to_cycles(input int clock_hz, input int ms);
    return (clock_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after 'last',
// optionally skipping one index (the current owner on handover).
module rr_pick4 (
  input  logic [3:0] request,
  input  logic [1:0] last,
  input  logic       exclude_en,
  input  logic [1:0] exclude_idx,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] w_cand [4];
  logic [3:0] w_ok;

  // Candidate gi is the (gi+1)-th position after last, so gi=3 is last itself.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign w_cand[gi] = last + 2'(gi + 1);
    assign w_ok[gi]   = request[w_cand[gi]] &&
                        !(exclude_en && (w_cand[gi] == exclude_idx));
  end

  always_comb begin
    found = |w_ok;
    idx   = w_cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (w_ok[k]) idx = w_cand[k];
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner arbitration of the shared 8-digit display with a
// minimum dwell time; all outputs are registered.
module display_arbiter
  import display_pkg::*;
#(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int HOLD_MS  = 500
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [3:0]   Request_i,
  input  logic [127:0] Data_i,
  input  logic [31:0]  DecimalPoints_i,
  output logic [3:0]   Grant_o,
  output logic [1:0]   Owner_o,
  output logic         Busy_o,
  output logic [31:0]  Data_o,
  output logic [7:0]   DecimalPoints_o
);

  localparam int HOLD_CYCLES = ms_to_cycles(CLOCK_HZ, HOLD_MS);
  localparam int CW          = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_last;
  logic [1:0]      r_owner;
  logic [3:0]      r_grant;
  logic            r_busy;
  logic [31:0]     r_data;
  logic [7:0]      r_dp;

  logic            w_found;
  logic [1:0]      w_pick;
  logic            w_owner_req;
  logic            w_expired;
  logic            w_take;
  logic            w_drop;
  logic [31:0]     w_pick_data;
  logic [7:0]      w_pick_dp;
  logic [31:0]     w_own_data;
  logic [7:0]      w_own_dp;

  rr_pick4 u_pick (
    .request     (Request_i),
    .last        (r_last),
    .exclude_en  (r_state != ST_IDLE),
    .exclude_idx (r_owner),
    .found       (w_found),
    .idx         (w_pick)
  );

  assign w_owner_req = Request_i[r_owner];
  // A HOLD owner whose counter reached 0 is treated as OPEN in the same
  // cycle, so it keeps the display for exactly HOLD_CYCLES cycles.
  assign w_expired   = (r_state == ST_OPEN) || ((r_state == ST_HOLD) && (r_cnt == '0));
  assign w_take      = (r_state == ST_IDLE) ? w_found
                                            : ((!w_owner_req || w_expired) && w_found);
  assign w_drop      = (r_state != ST_IDLE) && !w_owner_req && !w_found;

  assign w_pick_data = Data_i[{w_pick, 5'd0} +: 32];
  assign w_pick_dp   = DecimalPoints_i[{w_pick, 3'd0} +: 8];
  assign w_own_data  = Data_i[{r_owner, 5'd0} +: 32];
  assign w_own_dp    = DecimalPoints_i[{r_owner, 3'd0} +: 8];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 2'd3;
      r_owner <= 2'd0;
      r_grant <= 4'd0;
      r_busy  <= 1'b0;
      r_data  <= 32'd0;
      r_dp    <= 8'd0;
    end else if (w_take) begin
      r_state <= ST_HOLD;
      r_cnt   <= CNT_LOAD;
      r_last  <= w_pick;
      r_owner <= w_pick;
      r_grant <= 4'b0001 << w_pick;
      r_busy  <= 1'b1;
      r_data  <= w_pick_data;
      r_dp    <= w_pick_dp;
    end else if (w_drop || (r_state == ST_IDLE) || (r_state == ST_OPEN && 1'b0)) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= 2'd0;
      r_grant <= 4'd0;
      r_busy  <= 1'b0;
      r_data  <= 32'd0;
      r_dp    <= 8'd0;
    end else begin
      r_data <= w_own_data;
      r_dp   <= w_own_dp;
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == '0) r_state <= ST_OPEN;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_OPEN: r_cnt <= '0;
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 4'd0;
          r_busy  <= 1'b0;
          r_owner <= 2'd0;
        end
      endcase
    end
  end

  assign Grant_o         = r_grant;
  assign Owner_o         = r_owner;
  assign Busy_o          = r_busy;
  assign Data_o          = r_data;
  assign DecimalPoints_o = r_dp;

endmodule

// File: tb/tb_display_arbiter.sv
// Scenario bench for display_arbiter: each cycle's expected outputs are
// queued when inputs are driven and popped after the following clock edge.
module tb_display_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  words [4];
  logic [7:0]   dps [4];
  logic [127:0] data_in;
  logic [31:0]  dp_in;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic [31:0]  data_out;
  logic [7:0]   dp_out;
  logic [46:0]  obs;
  logic [46:0]  sb [$];
  logic [46:0]  e;
  int           total  = 0;
  int           passed = 0;

  always #5 clk = ~clk;

  assign data_in = {words[3], words[2], words[1], words[0]};
  assign dp_in   = {dps[3], dps[2], dps[1], dps[0]};
  assign obs     = {grant, owner, busy, data_out, dp_out};

  display_arbiter #(.CLOCK_HZ(10_000), .HOLD_MS(1)) dut (
    .Clock           (clk),
    .Reset           (rst),
    .Request_i       (req),
    .Data_i          (data_in),
    .DecimalPoints_i (dp_in),
    .Grant_o         (grant),
    .Owner_o         (owner),
    .Busy_o          (busy),
    .Data_o          (data_out),
    .DecimalPoints_o (dp_out)
  );

  // Expected output vector for a given grant, using the inputs presented now.
  function automatic logic [46:0] exp_of(input logic [3:0] g);
    logic [1:0] o;
    o = 2'd0;
    for (int n = 0; n < 4; n++) if (g[n]) o = 2'(n);
    if (g == 4'd0) return 47'd0;
    return {g, o, 1'b1, words[o], dps[o]};
  endfunction

  task automatic tick(input logic [3:0] g);
    sb.push_back(exp_of(g));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      tick((i == 2) ? 4'b0001 : 4'b0000);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL reset cyc%0d got=%h exp=%h", i, obs, e);
      else begin passed++; $display("ok reset cyc%0d grant=%b data=%h", i, grant, data_out); end
    end
  endtask

  task automatic test_dwell;
    logic [3:0] g;
    rst = 1'b1; req = 4'b0000;
    tick(4'b0000);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL dwell_rst got=%h exp=%h", obs, e); else passed++;
    rst = 1'b0;
    req = 4'b0011;
    for (int i = 0; i < 30; i++) begin
      g = (i < 10) ? 4'b0001 : (i < 20) ? 4'b0010 : 4'b0001;
      tick(g);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL dwell cyc%0d got=%h exp=%h", i, obs, e);
      else begin passed++; $display("ok dwell cyc%0d grant=%b", i, grant); end
    end
  endtask

  task automatic test_release;
    logic [3:0] g;
    rst = 1'b1; req = 4'b0000;
    tick(4'b0000);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL release_rst got=%h exp=%h", obs, e); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = (i < 3) ? 4'b0100 : (i == 3) ? 4'b0000 : 4'b0010;
      g   = req;
      tick(g);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL release cyc%0d got=%h exp=%h", i, obs, e);
      else begin passed++; $display("ok release cyc%0d grant=%b busy=%b", i, grant, busy); end
    end
  endtask

  task automatic test_handover;
    logic [3:0] g;
    rst = 1'b1; req = 4'b0000;
    tick(4'b0000);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL handover_rst got=%h exp=%h", obs, e); else passed++;
    rst = 1'b0;
    // 4 cycles of owner 0 with 3 waiting, drop, then 3 keeps a full dwell.
    for (int i = 0; i < 15; i++) begin
      req = (i < 4) ? 4'b1001 : (i == 4) ? 4'b1000 : 4'b1001;
      g   = (i < 4) ? 4'b0001 : (i < 14) ? 4'b1000 : 4'b0001;
      tick(g);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL handover cyc%0d got=%h exp=%h", i, obs, e);
      else begin passed++; $display("ok handover cyc%0d grant=%b", i, grant); end
    end
  endtask

  task automatic test_lone_open;
    rst = 1'b1; req = 4'b0000;
    tick(4'b0000);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL lone_rst got=%h exp=%h", obs, e); else passed++;
    rst = 1'b0;
    req = 4'b0001;
    words[0] = 32'h1234_5678;
    for (int i = 0; i < 52; i++) begin
      if (i == 50) words[0] = 32'hCAFE_0000;
      tick(4'b0001);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL lone cyc%0d got=%h exp=%h", i, obs, e);
      else begin passed++; $display("ok lone cyc%0d grant=%b data=%h", i, grant, data_out); end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] g;
    rst = 1'b1; req = 4'b0000;
    tick(4'b0000);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL rstmid_rst got=%h exp=%h", obs, e); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rst = (i == 5);
      req = (i < 5) ? 4'b0010 : 4'b0011;
      g   = (i < 5) ? 4'b0010 : (i == 5) ? 4'b0000 : 4'b0001;
      tick(g);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, obs, e);
      else begin passed++; $display("ok reset_mid cyc%0d grant=%b", i, grant); end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 4; n++) begin
      words[n] = 32'hA0B0_0000 + 32'(n * 32'h1111);
      dps[n]   = 8'(8'h11 * (n + 1));
    end
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    test_reset;
    test_dwell;
    test_release;
    test_handover;
    test_lone_open;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
